// File: rtl/csa_pkg.sv
// Shared constants and configuration checks for the pipelined carry-select adder.
package csa_pkg;

   // Number of carry-select blocks across the operand width.
   function automatic int calc_nblk(input int width, input int blk);
      return width / blk;
   endfunction

   // Number of pipeline stages when each stage resolves bps blocks.
   function automatic int calc_stages(input int width, input int blk, input int bps);
      return calc_nblk(width, blk) / bps;
   endfunction

   // True when the width splits evenly into blocks and the blocks evenly into stages.
   function automatic bit cfg_ok(input int width, input int blk, input int bps);
      return (blk > 0) && (bps > 0) && (width % blk == 0) && (calc_nblk(width, blk) % bps == 0);
   endfunction

endpackage

// File: rtl/csa_block.sv
// BLK-bit ripple block producing sum/carry for both possible carry-ins.
module csa_block #(
   parameter int BLK = 4
) (
   input  logic [BLK-1:0] a,
   input  logic [BLK-1:0] b,
   output logic [BLK-1:0] sum0,
   output logic           cout0,
   output logic [BLK-1:0] sum1,
   output logic           cout1
);

   logic c0;
   logic c1;

   // Two ripple chains, one assuming carry-in 0 and one assuming carry-in 1.
   always_comb begin
      // NOTE: every variable gets a value before any branch or loop, so no latch can be inferred.
      c0   = 1'b0;
      c1   = 1'b1;
      sum0 = '0;
      sum1 = '0;
      for (int i = 0; i < BLK; i++) begin
         // NOTE: blocking assignments here so each bit sees the carry from the bit just below it.
         sum0[i] = a[i] ^ b[i] ^ c0;
         c0      = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
         sum1[i] = a[i] ^ b[i] ^ c1;
         c1      = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
      end
      cout0 = c0;
      cout1 = c1;
   end

endmodule

// File: rtl/csa_adder_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake and pass-through tag.
// Stage s resolves blocks s*BPS .. s*BPS+BPS-1; the last stage feeds the output register.
module csa_adder_pipe
   import csa_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int BLK   = 4,
   parameter int BPS   = 2,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag
);

   localparam int NBLK   = calc_nblk(WIDTH, BLK);
   localparam int STAGES = NBLK / BPS;
   localparam int SPAN   = BPS * BLK;
   localparam int LAST   = STAGES - 1;

   if (!cfg_ok(WIDTH, BLK, BPS)) begin : g_bad_cfg
      $error("csa_adder_pipe: WIDTH must be a multiple of BLK and WIDTH/BLK a multiple of BPS");
   end

   // The whole pipe moves together whenever the output slot is free or being drained.
   logic en;
   assign en       = ~out_valid | out_ready;
   assign in_ready = en;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int LO = s * SPAN;

      // Stage inputs: operand bits not yet resolved, carry into block s*BPS,
      // sum bits resolved by earlier stages, and the control fields.
      logic [WIDTH-1:LO]      a_r;
      logic [WIDTH-1:LO]      b_r;
      logic [WIDTH-1:0]       sum_r;
      logic                   c_r;
      logic                   v_r;
      logic [TAG_W-1:0]       tag_r;

      logic [BPS-1:0][BLK-1:0] s0;
      logic [BPS-1:0][BLK-1:0] s1;
      logic [BPS-1:0]          co0;
      logic [BPS-1:0]          co1;
      logic [WIDTH-1:0]        sum_o;
      logic                    c_o;

      if (s == 0) begin : g_prep
         // Operand preparation: subtract is A + ~B + 1, so cin is forced high in sub mode.
         always_comb begin
            a_r   = in_a;
            b_r   = in_sub ? ~in_b : in_b;
            c_r   = in_sub | in_cin;
            sum_r = '0;
            v_r   = in_valid;
            tag_r = in_tag;
         end
      end else begin : g_reg
         // Stage valid bit: cleared by reset, shifts a bubble in when nothing was accepted.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               v_r <= 1'b0;
            end else if (en) begin
               v_r <= g_stage[s-1].v_r;
            end
         end

         // Stage datapath: only meaningful alongside v_r, so it is never reset.
         // NOTE: leaving wide data registers out of reset is safe because the valid bit gates their use.
         always_ff @(posedge clk) begin
            if (en) begin
               a_r   <= g_stage[s-1].a_r[WIDTH-1:LO];
               b_r   <= g_stage[s-1].b_r[WIDTH-1:LO];
               sum_r <= g_stage[s-1].sum_o;
               c_r   <= g_stage[s-1].c_o;
               tag_r <= g_stage[s-1].tag_r;
            end
         end
      end

      for (genvar k = 0; k < BPS; k++) begin : g_blk
         csa_block #(
            .BLK(BLK)
         ) u_blk (
            .a    (a_r[LO + k*BLK +: BLK]),
            .b    (b_r[LO + k*BLK +: BLK]),
            .sum0 (s0[k]),
            .cout0(co0[k]),
            .sum1 (s1[k]),
            .cout1(co1[k])
         );
      end

      // Carry-select chain: the real carry out of each block picks the next block's result.
      always_comb begin
         sum_o = sum_r;
         c_o   = c_r;
         for (int k = 0; k < BPS; k++) begin
            sum_o[LO + k*BLK +: BLK] = c_o ? s1[k] : s0[k];
            c_o                      = c_o ? co1[k] : co0[k];
         end
      end
   end

   // Carry into the MSB recovered from the MSB's own sum bit, used for signed overflow.
   logic msb_cin;
   assign msb_cin = g_stage[LAST].a_r[WIDTH-1] ^ g_stage[LAST].b_r[WIDTH-1] ^ g_stage[LAST].sum_o[WIDTH-1];

   // Output register with final flags; holds everything while the consumer stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
         out_zero  <= 1'b0;
         out_tag   <= '0;
      end else if (en) begin
         out_valid <= g_stage[LAST].v_r;
         out_sum   <= g_stage[LAST].sum_o;
         out_cout  <= g_stage[LAST].c_o;
         out_ovf   <= msb_cin ^ g_stage[LAST].c_o;
         out_zero  <= ~|g_stage[LAST].sum_o;
         out_tag   <= g_stage[LAST].tag_r;
      end
   end

endmodule

// File: tb/tb_csa_adder_pipe.sv
// Self-checking bench for csa_adder_pipe: arithmetic reference model plus directed and random traffic.
module tb_csa_adder_pipe;

   localparam int W      = 32;
   localparam int TW     = 4;
   localparam int STAGES = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_cin;
   logic          in_sub;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          out_ovf;
   logic          out_zero;
   logic [TW-1:0] out_tag;

   always #5 clk = ~clk;

   csa_adder_pipe #(
      .WIDTH(W),
      .BLK  (4),
      .BPS  (2),
      .TAG_W(TW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_cin   (in_cin),
      .in_sub   (in_sub),
      .in_tag   (in_tag),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_cout (out_cout),
      .out_ovf  (out_ovf),
      .out_zero (out_zero),
      .out_tag  (out_tag)
   );

   typedef struct {
      logic [W-1:0]  sum;
      logic          cout;
      logic          ovf;
      logic          zero;
      logic [TW-1:0] tag;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the operands, signed range test for overflow.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub, input logic [TW-1:0] tag);
      exp_t            e;
      longint unsigned ua;
      longint unsigned ub;
      longint          sa;
      longint          sb;
      longint          sres;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         e.sum  = a - b;
         e.cout = (ua >= ub);
         sres   = sa - sb;
      end else begin
         e.sum  = a + b + W'(cin);
         e.cout = ((ua + ub + longint'(cin)) >= 64'h1_0000_0000);
         sres   = sa + sb + longint'(cin);
      end
      e.ovf  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      e.zero = (e.sum == '0);
      e.tag  = tag;
      return e;
   endfunction

   // Compare process: every cycle, the visible result must match the oldest outstanding op.
   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         q.delete();
      end else begin
         check("in_ready_rule", in_ready, (!out_valid || out_ready));
         if (out_valid) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_result: got out_valid=1 tag=0x%0h, expected no result (t=%0t)", out_tag, $time);
            end else begin
               check("model_sum",  out_sum,  q[0].sum);
               check("model_cout", out_cout, q[0].cout);
               check("model_ovf",  out_ovf,  q[0].ovf);
               check("model_zero", out_zero, q[0].zero);
               check("model_tag",  out_tag,  q[0].tag);
               if (out_ready) void'(q.pop_front());
            end
         end
         if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_cin, in_sub, in_tag));
      end
   end

   function automatic logic [W-1:0] rand_opnd();
      case ($urandom_range(0, 7))
         0:       return '1;
         1:       return '0;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom();
      endcase
   endfunction

   task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub, input logic [TW-1:0] tag);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_sub   = sub;
      in_tag   = tag;
   endtask

   // One isolated op on an idle pipe; checks exact latency and literal results.
   task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [TW-1:0] tag, input logic [W-1:0] es,
                          input logic ec, input logic eo, input logic ez, input string nm);
      @(posedge clk);
      #1 drive_op(a, b, cin, sub, tag);
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (STAGES - 2) @(posedge clk);
      @(negedge clk);
      check({nm, "_early"}, out_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check({nm, "_valid"}, out_valid, 1'b1);
      check({nm, "_sum"},   out_sum,   es);
      check({nm, "_cout"},  out_cout,  ec);
      check({nm, "_ovf"},   out_ovf,   eo);
      check({nm, "_zero"},  out_zero,  ez);
      check({nm, "_tag"},   out_tag,   tag);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1 in_valid = 1'b0;
         out_ready = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its summary, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic acc;
      int   wait_cyc;

      // Reset held for two cycles with input offered.
      rst_n     = 1'b0;
      out_ready = 1'b1;
      drive_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 4'h9);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", out_valid, 1'b0);
      check("rst_sum",   out_sum,   '0);
      check("rst_cout",  out_cout,  1'b0);
      check("rst_ovf",   out_ovf,   1'b0);
      check("rst_zero",  out_zero,  1'b0);
      check("rst_tag",   out_tag,   '0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      idle(2);

      // Add and subtract boundaries.
      run_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "add_wrap");
      run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h2, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "add_ovf");
      run_one(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 4'h3, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, "sub_ovf");
      run_one(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 4'h4, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "sub_borrow");
      run_one(32'h0000_0FFF, 32'h0000_0000, 1'b1, 1'b0, 4'h5, 32'h0000_1000, 1'b0, 1'b0, 1'b0, "add_cin");
      idle(3);

      // Streaming: 8 back-to-back ops, results in cycles 4..11 in tag order.
      for (int k = 0; k < 16; k++) begin
         @(posedge clk);
         #1;
         if (k < 8) drive_op(rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'(k));
         else       in_valid = 1'b0;
         @(negedge clk);
         check($sformatf("stream_valid_c%0d", k), out_valid, (k >= 4 && k < 12));
         if (k >= 4 && k < 12) check($sformatf("stream_tag_c%0d", k), out_tag, TW'(k - 4));
      end
      idle(2);

      // Backpressure: stall the consumer for 3 cycles with the pipe full.
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1 out_ready = !(k >= 6 && k <= 8);
         if (k <= 6 || k == 10) drive_op(rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'(k));
         else if (k >= 11)      in_valid = 1'b0;
         @(negedge clk);
         if (k >= 6 && k <= 8) begin
            check($sformatf("bp_in_ready_c%0d", k), in_ready, 1'b0);
            check($sformatf("bp_valid_c%0d", k), out_valid, 1'b1);
            check($sformatf("bp_tag_c%0d", k), out_tag, TW'(2));
         end
      end
      idle(STAGES + 4);
      check("bp_drain_empty", q.size(), 0);

      // Mid-flight reset: three accepted ops must never emerge.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1 drive_op(rand_opnd(), rand_opnd(), 1'b0, 1'b0, TW'(10 + k));
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check($sformatf("mid_rst_quiet_c%0d", k), out_valid, 1'b0);
         @(posedge clk);
      end

      // Random traffic with random consumer stalls; inputs held until accepted.
      acc = 1'b1;
      in_valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk);
         #1;
         if (!in_valid || acc) begin
            if ($urandom_range(0, 9) < 7) drive_op(rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'($urandom()));
            else                          in_valid = 1'b0;
         end
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         acc = in_valid && in_ready;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      out_ready = 1'b1;
      wait_cyc = 0;
      while (q.size() != 0 && wait_cyc < 20) begin
         @(posedge clk);
         wait_cyc++;
      end
      @(negedge clk);
      check("final_drain_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
